// File: rtl/rv64_branch_pkg.sv
// Shared branch-resolution types: funct3 condition codes and the registered result bundle.
package rv64_branch_pkg;

   localparam int unsigned BR_XLEN = 64;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic               taken;
      logic [BR_XLEN-1:0] target;
      logic [BR_XLEN-1:0] link;
      logic               illegal;
      logic               misaligned;
   } br_result_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational RV64 branch condition: funct3 plus comparator flags -> taken/illegal.
module branch_cond
   import rv64_branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       eq,
   input  logic       ls,
   input  logic       lu,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = ~eq;
         F3_BLT:  taken = ls;
         F3_BGE:  taken = ~ls;
         F3_BLTU: taken = lu;
         F3_BGEU: taken = ~lu;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Single-entry branch resolve stage: condition, target/link, mispredict redirect, valid/ready.
// Optional build macro BRANCH_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_unit
   import rv64_branch_pkg::*;
#(
   parameter int unsigned       XLEN     = BR_XLEN,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic [2:0]      funct3,
   input  logic            eq,
   input  logic            ls,
   input  logic            lu,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link,
   output logic            illegal,
   output logic            misaligned,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_resolved,
   output logic [31:0]     stat_mispredict
`endif
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic            cond_taken, cond_illegal;
   logic            taken_p0, illegal_p0, misaligned_p0, redirect_p0, accept_p0;
   logic [XLEN-1:0] link_p0, pc_sum_p0, jalr_sum_p0, target_p0, next_pc_p0;
   br_result_t      res_p0, res_p1;
   logic [0:0]      state_p1;
   logic            redir_vld_p1;
   logic [XLEN-1:0] redir_pc_p1;

   branch_cond u_cond (
      .funct3  (funct3),
      .eq      (eq),
      .ls      (ls),
      .lu      (lu),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   // p0: resolve direction, target and prediction check from the incoming op
   assign link_p0     = pc + XLEN'(4);
   assign pc_sum_p0   = pc + imm;
   assign jalr_sum_p0 = rs1 + imm;
   assign taken_p0    = is_jal | is_jalr | (is_branch & cond_taken);
   assign illegal_p0  = is_branch & ~is_jal & ~is_jalr & cond_illegal;

   always_comb begin
      target_p0 = link_p0;
      if (taken_p0) begin
         if (is_jalr) target_p0 = {jalr_sum_p0[XLEN-1:1], 1'b0};
         else         target_p0 = pc_sum_p0;
      end
   end

   assign misaligned_p0 = taken_p0 & (|target_p0[1:0]);
   // A misaligned target traps, so the trap path redirects instead of us.
   assign redirect_p0   = (taken_p0 ^ pred_taken) & ~misaligned_p0;
   assign next_pc_p0    = taken_p0 ? target_p0 : link_p0;

   assign res_p0 = '{taken: taken_p0, target: target_p0, link: link_p0,
                     illegal: illegal_p0, misaligned: misaligned_p0};

   assign out_valid = (state_p1 == ST_FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign accept_p0 = in_valid & in_ready & ~flush;

   // p1: result register; redirect pulses only on the load cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1     <= ST_EMPTY;
         res_p1       <= '0;
         redir_vld_p1 <= 1'b0;
         redir_pc_p1  <= RESET_PC;
      end else if (flush) begin
         state_p1     <= ST_EMPTY;
         redir_vld_p1 <= 1'b0;
      end else if (accept_p0) begin
         state_p1     <= ST_FULL;
         res_p1       <= res_p0;
         redir_vld_p1 <= redirect_p0;
         redir_pc_p1  <= next_pc_p0;
      end else begin
         redir_vld_p1 <= 1'b0;
         if (out_ready) state_p1 <= ST_EMPTY;
      end
   end

   assign taken          = res_p1.taken;
   assign target         = res_p1.target;
   assign link           = res_p1.link;
   assign illegal        = res_p1.illegal;
   assign misaligned     = res_p1.misaligned;
   assign redirect_valid = redir_vld_p1;
   assign redirect_pc    = redir_pc_p1;

`ifdef BRANCH_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_resolved   <= '0;
         stat_mispredict <= '0;
      end else begin
         stat_resolved   <= sat_inc(stat_resolved, accept_p0);
         stat_mispredict <= sat_inc(stat_mispredict, accept_p0 & redirect_p0);
      end
   end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Single-entry pipeline stage directly downstream of the integer comparator (eq/ls/lu flags) and the 64-bit subtracting adder. Evaluates the RV64 branch condition, computes the branch/jump target and link address, and checks the front-end prediction. Registers one resolved result with a valid/ready handshake and raises a one-shot redirect on misprediction.

Parameters:
XLEN, 64, datapath width for pc/imm/rs1/target.
RESET_PC, 64'h0, value driven on redirect_pc while reset is asserted.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the held entry and the input this cycle
in_valid  in  1  upstream holds a valid op
in_ready  out  1  stage can accept an op
is_branch  in  1  conditional branch
is_jal  in  1  JAL
is_jalr  in  1  JALR
funct3  in  3  branch condition code
eq  in  1  comparator equality
ls  in  1  comparator signed less-than
lu  in  1  comparator unsigned less-than
pred_taken  in  1  front-end prediction
pc  in  XLEN  instruction address
imm  in  XLEN  sign-extended offset
rs1  in  XLEN  JALR base
out_valid  out  1  result register full
out_ready  in  1  downstream accepts
taken  out  1  resolved direction
target  out  XLEN  resolved target
link  out  XLEN  pc+4
illegal  out  1  reserved funct3 (010/011) on a branch
misaligned  out  1  taken and target[1:0] != 0
redirect_valid  out  1  one-cycle mispredict pulse
redirect_pc  out  XLEN  correct next pc

Behaviour:
- Reset (async, rst_n=0): out_valid=0, redirect_valid=0, taken=0, illegal=0, misaligned=0, target=0, link=0, redirect_pc=RESET_PC; state EMPTY.
- Handshake: in_ready = !out_valid || out_ready. Accept when in_valid && in_ready && !flush. Latency 1 cycle: result visible the cycle after accept.
- Condition: 000 eq; 001 !eq; 100 ls; 101 !ls; 110 lu; 111 !lu; 010/011 not taken, illegal=1. JAL/JALR always taken, illegal=0. No flag set -> not taken, target=pc+4.
- Targets: branch/JAL pc+imm; JALR (rs1+imm) with bit0 cleared; all sums wrap modulo 2^XLEN.
- Mispredict = taken != pred_taken. Correct pc = taken ? target : pc+4. misaligned forces redirect_valid=0 (trap path owns it).
- FSM: EMPTY -> FULL on accept. FULL -> EMPTY on out_ready without new accept; FULL -> FULL on out_ready with accept (back-to-back, no bubble); FULL holds all outputs stable while out_ready=0.
- redirect_valid asserted only in the first cycle an entry is FULL; never re-asserted while stalled.
- flush: next cycle out_valid=0, redirect_valid=0, state EMPTY; flush wins over simultaneous accept and out_ready.
- Reset mid-operation drops the entry immediately; no redirect emitted.
- Inputs with none of is_branch/is_jal/is_jalr and in_valid=1 pass through as not taken, no redirect.

Optional Feature:
BRANCH_STATS_EN: adds outputs stat_resolved[31:0] and stat_mispredict[31:0]. Both count accepted, non-flushed ops (all ops / those raising redirect_valid), saturate at 32'hFFFFFFFF, reset to 0. Without the macro the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package rv64_branch_pkg: funct3 localparams (BEQ..BGEU), typedef for the result bundle {taken, target, link, illegal, misaligned}.
- Sub-module branch_cond: purely combinational funct3 + eq/ls/lu -> taken/illegal; reused by the verification model.

Test Plan:
- BLT funct3=100, ls=1, pc=0x1000, imm=0x20, pred_taken=0 -> next cycle out_valid=1, taken=1, target=0x1020, redirect_valid=1 for exactly one cycle, redirect_pc=0x1020.
- BGEU funct3=111, lu=1, pred_taken=0, pc=0x2000 -> taken=0, target=0x2004, redirect_valid=0.
- JALR rs1=0x3001, imm=0x10, pred_taken=1 -> target=0x3010, link=pc+4, misaligned=0, no redirect; rs1=0x3002 -> misaligned=1, redirect_valid=0.
- out_ready=0 for 3 cycles after mispredicting BEQ -> outputs stable, in_ready=0, redirect_valid high only the first cycle; then out_ready=1 with new in_valid -> back-to-back accept, no bubble.
- flush asserted with in_valid=1 while FULL -> next cycle out_valid=0, no redirect; funct3=010 branch -> illegal=1, taken=0.
- Async rst_n low mid-FULL -> out_valid=0 immediately, redirect_pc=RESET_PC; with BRANCH_STATS_EN, counters 0 after reset and reach 10/4 after 10 ops with 4 mispredicts.
